// File: rtl/cache.sv
// Direct-mapped write-through data cache (one word per line) in front of a fixed-latency
// word-addressed backing memory. Define CACHE_WRITE_ALLOCATE_EN to fill lines on write misses.
module cache #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int INDEX_W     = 5,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Mem_read,
    input  logic              Mem_write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_in,
    output logic              Stall,
    output logic [DATA_W-1:0] Data_out
);

    localparam int TAG_W     = ADDR_W - INDEX_W;
    localparam int LINES     = 1 << INDEX_W;
    localparam int MEM_WORDS = 1 << ADDR_W;
    localparam int CNT_W     = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

`ifdef CACHE_WRITE_ALLOCATE_EN
    localparam logic WR_ALLOC = 1'b1;
`else
    localparam logic WR_ALLOC = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DONE     = 2'd2
    } state_t;

    function automatic logic tag_hit(input logic v,
                                     input logic [TAG_W-1:0] stored,
                                     input logic [TAG_W-1:0] req);
        return v && (stored == req);
    endfunction

    logic [DATA_W-1:0] mem_r       [MEM_WORDS];
    logic [DATA_W-1:0] line_data_r [LINES];
    logic [TAG_W-1:0]  line_tag_r  [LINES];
    logic [LINES-1:0]  valid_r;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              op_write_r;

    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [INDEX_W-1:0] lat_idx_s;
    logic [TAG_W-1:0]   lat_tag_s;
    logic               hit_s;
    logic               lat_hit_s;
    logic               req_read_s;
    logic               req_write_s;
    logic               same_req_s;
    logic               start_s;
    logic               finish_s;
    logic               fill_s;
    logic               mem_we_s;
    logic               line_wr_s;
    logic               stall_s;

    assign idx_s     = Address[INDEX_W-1:0];
    assign tag_s     = Address[ADDR_W-1:INDEX_W];
    assign lat_idx_s = addr_r[INDEX_W-1:0];
    assign lat_tag_s = addr_r[ADDR_W-1:INDEX_W];

    // Request decode, hit detection and completion strobes
    always_comb begin
        req_write_s = Mem_write;
        req_read_s  = Mem_read & ~Mem_write;
        hit_s       = tag_hit(valid_r[idx_s], line_tag_r[idx_s], tag_s);
        lat_hit_s   = tag_hit(valid_r[lat_idx_s], line_tag_r[lat_idx_s], lat_tag_s);
        start_s     = req_write_s | (req_read_s & ~hit_s);
        same_req_s  = (Mem_read | Mem_write) && (Mem_write == op_write_r) && (Address == addr_r);
        finish_s    = reset && (state_r == MEM_WAIT) && (cnt_r == {CNT_W{1'b0}});
        fill_s      = finish_s & ~op_write_r;
        mem_we_s    = finish_s & op_write_r;
        line_wr_s   = mem_we_s & (lat_hit_s | WR_ALLOC);
    end

    // Stall must rise in the same cycle a miss or write is presented
    always_comb begin
        stall_s = 1'b0;
        if (!reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:     stall_s = start_s;
                MEM_WAIT: stall_s = 1'b1;
                DONE:     stall_s = 1'b0;
                default:  stall_s = 1'b0;
            endcase
        end
    end

    assign Stall = stall_s;

    // Backing memory and line storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= wdata_r;
        end
        if (fill_s) begin
            line_data_r[lat_idx_s] <= mem_r[addr_r];
            line_tag_r[lat_idx_s]  <= lat_tag_s;
        end else if (line_wr_s) begin
            line_data_r[lat_idx_s] <= wdata_r;
            line_tag_r[lat_idx_s]  <= lat_tag_s;
        end
    end

    // Valid bits, cleared by reset so every line starts empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= {LINES{1'b0}};
        end else if (fill_s || line_wr_s) begin
            valid_r[lat_idx_s] <= 1'b1;
        end
    end

    // Control FSM: latches the request, counts memory latency, drives Data_out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            op_write_r <= 1'b0;
            Data_out   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        addr_r     <= Address;
                        wdata_r    <= Data_in;
                        op_write_r <= req_write_s;
                        cnt_r      <= CNT_INIT;
                        state_r    <= MEM_WAIT;
                    end else if (req_read_s) begin
                        Data_out <= line_data_r[idx_s];
                    end
                end
                MEM_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (!op_write_r) begin
                            Data_out <= mem_r[addr_r];
                        end
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Holding the same request here keeps a write from being replayed
                    if (!same_req_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: directed table, multi-cycle corner sequences and
// randomized traffic checked against a residency/memory reference model.
module tb_cache;

    localparam int STALL_N = 3;
`ifdef CACHE_WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        Mem_read;
    logic        Mem_write;
    logic [9:0]  Address;
    logic [31:0] Data_in;
    logic        Stall;
    logic [31:0] Data_out;

    int n_checks = 0;
    int n_errors = 0;

    cache dut (
        .clk      (clk),
        .reset    (reset),
        .Mem_read (Mem_read),
        .Mem_write(Mem_write),
        .Address  (Address),
        .Data_in  (Data_in),
        .Stall    (Stall),
        .Data_out (Data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        int          exp_stall;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[16];

    // Reference model: memory image plus which address each line currently holds.
    // Write-through keeps any resident line equal to memory, so read data is mem_m[a].
    logic [31:0] mem_m [1024];
    int          resident [32];
    logic [31:0] last_dout;
    logic [9:0]  pool [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_stall(input logic rd, input logic wr, input logic [9:0] a);
        if (rd && !wr && resident[int'(a) % 32] == int'(a)) return 0;
        return STALL_N;
    endfunction

    task automatic model_apply(input logic rd, input logic wr, input logic [9:0] a,
                               input logic [31:0] d);
        int idx;
        idx = int'(a) % 32;
        if (wr) begin
            mem_m[a] = d;
            if (resident[idx] == int'(a) || ALLOC) resident[idx] = int'(a);
        end else if (rd) begin
            resident[idx] = int'(a);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) resident[i] = -1;
        last_dout = 32'h0;
    endtask

    // Counts cycles with Stall high, sampled on the falling edge, bounded
    task automatic wait_stall(input bit glitch, input logic [31:0] d,
                              output int stalls, output bit tmo);
        bit done;
        stalls = 0;
        done   = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (Stall) begin
                stalls++;
                @(posedge clk);
                #1;
                if (glitch) Data_in = ~d;
            end else begin
                done = 1'b1;
            end
        end
        tmo = !done;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [9:0] a,
                             input logic [31:0] d, input bit glitch,
                             output int stalls, output bit tmo);
        Mem_read  = rd;
        Mem_write = wr;
        Address   = a;
        Data_in   = d;
        wait_stall(glitch, d, stalls, tmo);
        @(posedge clk);
        #1;
        Mem_read  = 1'b0;
        Mem_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int          stalls;
    bit          tmo;
    int          exp_st;
    logic [31:0] exp_d;
    logic [9:0]  a;
    logic [31:0] d;
    logic        rd;
    logic        wr;

    initial begin
        reset     = 1'b0;
        Mem_read  = 1'b0;
        Mem_write = 1'b0;
        Address   = 10'h0;
        Data_in   = 32'h0;
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;
        model_reset();

        vecs[0]  = '{1'b0, 1'b1, 10'h003, 32'h12345678, 3, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 10'h003, 32'h0,        3, 32'h12345678};
        vecs[2]  = '{1'b0, 1'b1, 10'h004, 32'hAABBCCDD, 3, 32'h12345678};
        vecs[3]  = '{1'b1, 1'b0, 10'h004, 32'h0,        3, 32'hAABBCCDD};
        vecs[4]  = '{1'b0, 1'b1, 10'h007, 32'hFFFFFFFF, 3, 32'hAABBCCDD};
        vecs[5]  = '{1'b1, 1'b0, 10'h007, 32'h0,        3, 32'hFFFFFFFF};
        vecs[6]  = '{1'b0, 1'b1, 10'h003, 32'h87654321, 3, 32'hFFFFFFFF};
        vecs[7]  = '{1'b1, 1'b0, 10'h003, 32'h0,        0, 32'h87654321};
        vecs[8]  = '{1'b0, 1'b1, 10'h008, 32'hABCDEF01, 3, 32'h87654321};
        vecs[9]  = '{1'b1, 1'b0, 10'h008, 32'h0,        ALLOC ? 0 : 3, 32'hABCDEF01};
        vecs[10] = '{1'b0, 1'b1, 10'h028, 32'h5A5A5A5A, 3, 32'hABCDEF01};
        vecs[11] = '{1'b1, 1'b0, 10'h008, 32'h0,        ALLOC ? 3 : 0, 32'hABCDEF01};
        vecs[12] = '{1'b1, 1'b0, 10'h028, 32'h0,        3, 32'h5A5A5A5A};
        vecs[13] = '{1'b1, 1'b0, 10'h008, 32'h0,        3, 32'hABCDEF01};
        vecs[14] = '{1'b1, 1'b1, 10'h008, 32'h0BADF00D, 3, 32'hABCDEF01};
        vecs[15] = '{1'b1, 1'b0, 10'h008, 32'h0,        0, 32'h0BADF00D};

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(Stall), 32'h0);
        check("reset_dout", Data_out, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_stall", 32'(Stall), 32'h0);
        check("post_reset_dout", Data_out, 32'h0);

        // Directed table
        for (int i = 0; i < 16; i++) begin
            do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, stalls, tmo);
            check($sformatf("vec%0d_timeout", i), 32'(tmo), 32'h0);
            check($sformatf("vec%0d_stall", i), 32'(stalls), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_dout", i), Data_out, vecs[i].exp_dout);
            model_apply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data);
            last_dout = vecs[i].exp_dout;
        end

        // Held write in DONE must not be replayed with the changed data
        a = 10'h010;
        exp_st = model_stall(1'b0, 1'b1, a);
        Mem_write = 1'b1;
        Address   = a;
        Data_in   = 32'h11111111;
        wait_stall(1'b0, Data_in, stalls, tmo);
        check("hold_stall_cnt", 32'(stalls), 32'(exp_st));
        for (int k = 0; k < 3; k++) begin
            Data_in = 32'h22222222;
            @(posedge clk);
            #1;
            @(negedge clk);
            check("hold_no_stall", 32'(Stall), 32'h0);
        end
        @(posedge clk);
        #1;
        Mem_write = 1'b0;
        @(posedge clk);
        #1;
        model_apply(1'b0, 1'b1, a, 32'h11111111);
        exp_st = model_stall(1'b1, 1'b0, a);
        do_access(1'b1, 1'b0, a, 32'h0, 1'b0, stalls, tmo);
        check("hold_read_stall", 32'(stalls), 32'(exp_st));
        check("hold_read_dout", Data_out, 32'h11111111);
        model_apply(1'b1, 1'b0, a, 32'h0);

        // Data_in changing during MEM_WAIT is ignored
        a = 10'h020;
        do_access(1'b0, 1'b1, a, 32'hC0FFEE00, 1'b1, stalls, tmo);
        check("glitch_wr_stall", 32'(stalls), 32'(STALL_N));
        model_apply(1'b0, 1'b1, a, 32'hC0FFEE00);
        exp_st = model_stall(1'b1, 1'b0, a);
        do_access(1'b1, 1'b0, a, 32'h0, 1'b0, stalls, tmo);
        check("glitch_rd_stall", 32'(stalls), 32'(exp_st));
        check("glitch_rd_dout", Data_out, 32'hC0FFEE00);
        model_apply(1'b1, 1'b0, a, 32'h0);

        // Reset in the last MEM_WAIT cycle of a write aborts it
        Mem_write = 1'b1;
        Address   = 10'h010;
        Data_in   = 32'h33333333;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_stall", 32'(Stall), 32'h0);
        check("abort_dout", Data_out, 32'h0);
        Mem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        do_access(1'b1, 1'b0, 10'h010, 32'h0, 1'b0, stalls, tmo);
        check("abort_rd_stall", 32'(stalls), 32'(STALL_N));
        check("abort_rd_dout", Data_out, 32'h11111111);
        model_apply(1'b1, 1'b0, 10'h010, 32'h0);
        last_dout = 32'h11111111;

        // Randomized traffic over a pool of conflicting addresses
        for (int i = 0; i < 16; i++) begin
            pool[i] = 10'((((i % 4) * 7 + 3) * 32) + ((i / 4) * 9 + 2));
            d = $urandom;
            exp_st = model_stall(1'b0, 1'b1, pool[i]);
            do_access(1'b0, 1'b1, pool[i], d, 1'b0, stalls, tmo);
            check("pre_stall", 32'(stalls), 32'(exp_st));
            model_apply(1'b0, 1'b1, pool[i], d);
        end
        for (int n = 0; n < 150; n++) begin
            int r;
            r  = int'($urandom_range(0, 3));
            a  = pool[$urandom_range(0, 15)];
            d  = $urandom;
            rd = (r != 2);
            wr = (r >= 2);
            exp_st = model_stall(rd, wr, a);
            model_apply(rd, wr, a, d);
            exp_d = wr ? last_dout : mem_m[a];
            do_access(rd, wr, a, d, 1'b0, stalls, tmo);
            check("rnd_timeout", 32'(tmo), 32'h0);
            check("rnd_stall", 32'(stalls), 32'(exp_st));
            check("rnd_dout", Data_out, exp_d);
            last_dout = exp_d;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
